// File: rtl/multi_chan_counter_if.sv
// Bundle of the control and observation signals of the multi-channel counter bank.
// Ports: Slt/En/Dir/Sat/Load/LoadVal/Clr go towards the counter bank; Count/Ovf/Tick come back.
// master = stimulus/controller side, slave = counter bank side.
interface multi_chan_counter_if #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
);
  logic [SEL_W-1:0]          Slt;
  logic                      En;
  logic                      Dir;
  logic                      Sat;
  logic                      Load;
  logic [WIDTH-1:0]          LoadVal;
  logic                      Clr;
  logic [CHANNELS*WIDTH-1:0] Count;
  logic [CHANNELS-1:0]       Ovf;
  logic                      Tick;

  modport master (
    output Slt, En, Dir, Sat, Load, LoadVal, Clr,
    input  Count, Ovf, Tick
  );

  modport slave (
    input  Slt, En, Dir, Sat, Load, LoadVal, Clr,
    output Count, Ovf, Tick
  );
endinterface

// File: rtl/multi_chan_counter.sv
// Bank of CHANNELS WIDTH-bit up/down counters; one channel (Slt) is cleared, loaded or stepped per cycle.
// Latency: every effect shows on Count/Ovf/Tick one cycle after the sampling edge.
// Backpressure: none; every cycle's command is accepted. Ports: Clk, Reset (async active-low), bus (slave modport).
module multi_chan_counter #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1,
  parameter int DIV      = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  multi_chan_counter_if.slave   bus
);

  // Prescaler needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int              PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX    = '1;

  logic [PC_W-1:0]           pc_q, pc_d;
  logic [CHANNELS*WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]       ovf_q, ovf_d;
  logic                      tick_q, tick_d;
  logic [WIDTH-1:0]          cur;

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    cur    = '0;
    tick_d = bus.En && (pc_q == PC_LAST);

    // Prescaler runs on En alone, independent of channel selection and Clr/Load.
    if (bus.En) begin
      pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
    end

    // An out-of-range Slt matches no index, so every channel holds.
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.Slt == SEL_W'(i)) begin
        cur = cnt_q[i*WIDTH +: WIDTH];
        if (bus.Clr) begin
          cnt_d[i*WIDTH +: WIDTH] = '0;
          ovf_d[i]                = 1'b0;
        end else if (bus.Load) begin
          cnt_d[i*WIDTH +: WIDTH] = bus.LoadVal;
        end else if (tick_d) begin
          if (!bus.Dir) begin
            if (cur == MAX) begin
              ovf_d[i] = 1'b1;
              if (!bus.Sat) cnt_d[i*WIDTH +: WIDTH] = '0;
            end else begin
              cnt_d[i*WIDTH +: WIDTH] = cur + WIDTH'(1);
            end
          end else begin
            if (cur == '0) begin
              ovf_d[i] = 1'b1;
              if (!bus.Sat) cnt_d[i*WIDTH +: WIDTH] = MAX;
            end else begin
              cnt_d[i*WIDTH +: WIDTH] = cur - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      tick_q <= tick_d;
    end
  end

  assign bus.Count = cnt_q;
  assign bus.Ovf   = ovf_q;
  assign bus.Tick  = tick_q;

endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench for multi_chan_counter: four instances cover the 64-bit, 8-bit/4-channel,
// prescaled (DIV=3) and 3-channel out-of-range-select configurations.
module tb_multi_chan_counter;

  logic Clk;
  logic rst0, rst1, rst2, rst3;
  int   errors = 0;
  int   checks = 0;

  multi_chan_counter_if #(.WIDTH(64), .CHANNELS(2), .SEL_W(1)) if0 ();
  multi_chan_counter_if #(.WIDTH(8),  .CHANNELS(4), .SEL_W(2)) if1 ();
  multi_chan_counter_if #(.WIDTH(8),  .CHANNELS(2), .SEL_W(1)) if2 ();
  multi_chan_counter_if #(.WIDTH(8),  .CHANNELS(3), .SEL_W(2)) if3 ();

  multi_chan_counter #(.WIDTH(64), .CHANNELS(2), .SEL_W(1), .DIV(1)) u0 (.Clk(Clk), .Reset(rst0), .bus(if0.slave));
  multi_chan_counter #(.WIDTH(8),  .CHANNELS(4), .SEL_W(2), .DIV(1)) u1 (.Clk(Clk), .Reset(rst1), .bus(if1.slave));
  multi_chan_counter #(.WIDTH(8),  .CHANNELS(2), .SEL_W(1), .DIV(3)) u2 (.Clk(Clk), .Reset(rst2), .bus(if2.slave));
  multi_chan_counter #(.WIDTH(8),  .CHANNELS(3), .SEL_W(2), .DIV(1)) u3 (.Clk(Clk), .Reset(rst3), .bus(if3.slave));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    {if0.Slt, if0.En, if0.Dir, if0.Sat, if0.Load, if0.LoadVal, if0.Clr} = '0;
    {if1.Slt, if1.En, if1.Dir, if1.Sat, if1.Load, if1.LoadVal, if1.Clr} = '0;
    {if2.Slt, if2.En, if2.Dir, if2.Sat, if2.Load, if2.LoadVal, if2.Clr} = '0;
    {if3.Slt, if3.En, if3.Dir, if3.Sat, if3.Load, if3.LoadVal, if3.Clr} = '0;
    #12;
    checks++;
    if ({if0.Count, if1.Count, if2.Count, if3.Count} !== '0) begin
      errors++;
      $display("FAIL reset_count: got %h required 0", {if0.Count, if1.Count, if2.Count, if3.Count});
    end
    checks++;
    if ({if0.Ovf, if1.Ovf, if2.Ovf, if3.Ovf} !== '0) begin
      errors++;
      $display("FAIL reset_ovf: got %b required 0", {if0.Ovf, if1.Ovf, if2.Ovf, if3.Ovf});
    end
    checks++;
    if ({if0.Tick, if1.Tick, if2.Tick, if3.Tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_tick: got %b required 0000", {if0.Tick, if1.Tick, if2.Tick, if3.Tick});
    end
    step();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
  endtask

  // 64-bit, DIV=1: reset pulse then ten up-counts on channel 1.
  task automatic test_basic_count();
    if0.Slt = 1'b1; if0.En = 1'b1; if0.Dir = 1'b0; if0.Sat = 1'b0;
    rst0 = 1'b0;
    #10;
    rst0 = 1'b1;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (if0.Count[127:64] !== 64'd10) begin
      errors++;
      $display("FAIL basic_ch1: got %0d required 10", if0.Count[127:64]);
    end
    checks++;
    if (if0.Count[63:0] !== 64'd0) begin
      errors++;
      $display("FAIL basic_ch0: got %0d required 0", if0.Count[63:0]);
    end
    checks++;
    if (if0.Ovf !== 2'b00) begin
      errors++;
      $display("FAIL basic_ovf: got %b required 00", if0.Ovf);
    end
    if0.En = 1'b0;
  endtask

  // Load FE on ch2, wrap through FF->00->01, then Clr.
  task automatic test_wrap_up();
    logic [31:0] exp_cnt [5];
    logic [3:0]  exp_ovf [5];
    exp_cnt = '{32'h00FE0000, 32'h00FF0000, 32'h00000000, 32'h00010000, 32'h00000000};
    exp_ovf = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    if1.Slt = 2'd2; if1.Load = 1'b1; if1.LoadVal = 8'hFE; if1.Dir = 1'b0; if1.Sat = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin if1.Load = 1'b0; if1.En = 1'b1; end
      if (k == 4) begin if1.En = 1'b0; if1.Clr = 1'b1; end
      step();
      checks++;
      if (if1.Count !== exp_cnt[k]) begin
        errors++;
        $display("FAIL wrap_up_count[%0d]: got %h required %h", k, if1.Count, exp_cnt[k]);
      end
      checks++;
      if (if1.Ovf !== exp_ovf[k]) begin
        errors++;
        $display("FAIL wrap_up_ovf[%0d]: got %b required %b", k, if1.Ovf, exp_ovf[k]);
      end
    end
    if1.Clr = 1'b0;
  endtask

  // Down-saturate ch1 at 0, recount up; then down-wrap and up-saturate on ch0.
  task automatic test_saturate();
    logic [31:0] exp_cnt [5];
    logic [3:0]  exp_ovf [5];
    exp_cnt = '{32'h00000000, 32'h00000000, 32'h00000100, 32'h000001FF, 32'h000001FF};
    exp_ovf = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011};
    if1.Slt = 2'd1; if1.En = 1'b1; if1.Dir = 1'b1; if1.Sat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) if1.Dir = 1'b0;
      if (k == 3) begin if1.Slt = 2'd0; if1.Dir = 1'b1; if1.Sat = 1'b0; end
      if (k == 4) begin if1.Dir = 1'b0; if1.Sat = 1'b1; end
      step();
      checks++;
      if (if1.Count !== exp_cnt[k]) begin
        errors++;
        $display("FAIL saturate_count[%0d]: got %h required %h", k, if1.Count, exp_cnt[k]);
      end
      checks++;
      if (if1.Ovf !== exp_ovf[k]) begin
        errors++;
        $display("FAIL saturate_ovf[%0d]: got %b required %b", k, if1.Ovf, exp_ovf[k]);
      end
    end
    if1.En = 1'b0; if1.Sat = 1'b0;
  endtask

  // DIV=3: counts on every third enabled cycle, Tick follows, holds while En=0.
  task automatic test_prescaler();
    logic [15:0] exp_cnt;
    logic        exp_tick;
    if2.Slt = 1'b0; if2.En = 1'b1; if2.Dir = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_cnt  = 16'(k / 3);
      exp_tick = (k % 3 == 0);
      checks++;
      if (if2.Count !== exp_cnt) begin
        errors++;
        $display("FAIL prescale_count[%0d]: got %h required %h", k, if2.Count, exp_cnt);
      end
      checks++;
      if (if2.Tick !== exp_tick) begin
        errors++;
        $display("FAIL prescale_tick[%0d]: got %b required %b", k, if2.Tick, exp_tick);
      end
    end
    if2.En = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (if2.Count !== 16'h0003 || if2.Tick !== 1'b0) begin
      errors++;
      $display("FAIL prescale_hold: got %h/%b required 0003/0", if2.Count, if2.Tick);
    end
    if2.En = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_cnt  = (k == 3) ? 16'h0004 : 16'h0003;
      exp_tick = (k == 3);
      checks++;
      if (if2.Count !== exp_cnt || if2.Tick !== exp_tick) begin
        errors++;
        $display("FAIL prescale_resume[%0d]: got %h/%b required %h/%b", k, if2.Count, if2.Tick, exp_cnt, exp_tick);
      end
    end
    if2.En = 1'b0;
  endtask

  // Clr beats Load beats count on ch3.
  task automatic test_priority();
    if1.Slt = 2'd3; if1.Load = 1'b1; if1.LoadVal = 8'd7; if1.En = 1'b0;
    step();
    checks++;
    if (if1.Count !== 32'h070001FF) begin
      errors++;
      $display("FAIL prio_preload: got %h required 070001FF", if1.Count);
    end
    if1.Clr = 1'b1; if1.LoadVal = 8'd5; if1.En = 1'b1; if1.Dir = 1'b0;
    step();
    checks++;
    if (if1.Count !== 32'h000001FF || if1.Ovf !== 4'b0011) begin
      errors++;
      $display("FAIL prio_clr: got %h/%b required 000001FF/0011", if1.Count, if1.Ovf);
    end
    if1.Clr = 1'b0;
    step();
    checks++;
    if (if1.Count !== 32'h050001FF) begin
      errors++;
      $display("FAIL prio_load: got %h required 050001FF", if1.Count);
    end
    if1.Load = 1'b0;
    step();
    checks++;
    if (if1.Count !== 32'h060001FF) begin
      errors++;
      $display("FAIL prio_count: got %h required 060001FF", if1.Count);
    end
    if1.En = 1'b0;
  endtask

  // Out-of-range Slt changes nothing; async reset clears at once.
  task automatic test_out_of_range_reset();
    if3.Slt = 2'd0; if3.Load = 1'b1; if3.LoadVal = 8'd9;
    step();
    checks++;
    if (if3.Count !== 24'h000009) begin
      errors++;
      $display("FAIL oor_preload: got %h required 000009", if3.Count);
    end
    if3.Slt = 2'd3; if3.En = 1'b1; if3.LoadVal = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (if3.Count !== 24'h000009 || if3.Ovf !== 3'b000 || if3.Tick !== 1'b1) begin
        errors++;
        $display("FAIL oor_hold[%0d]: got %h/%b/%b required 000009/000/1", k, if3.Count, if3.Ovf, if3.Tick);
      end
    end
    rst3 = 1'b0;
    #1;
    checks++;
    if (if3.Count !== 24'h000000 || if3.Tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b required 000000/0", if3.Count, if3.Tick);
    end
    step();
    checks++;
    if (if3.Count !== 24'h000000) begin
      errors++;
      $display("FAIL reset_held: got %h required 000000", if3.Count);
    end
    rst3 = 1'b1; if3.Slt = 2'd0; if3.Load = 1'b0;
    step();
    checks++;
    if (if3.Count !== 24'h000001) begin
      errors++;
      $display("FAIL reset_resume: got %h required 000001", if3.Count);
    end
    if3.En = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_wrap_up();
    test_saturate();
    test_prescaler();
    test_priority();
    test_out_of_range_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
